message_parser: RTL
===================

MESSAGE_PARSER -- requirements
Module: message_parser

Interface
REQ-001 Parameter: WIDTH, 32, bits per word; SHALL be a multiple of 4.
REQ-002 Parameter: COUNT, 2, words per message.
REQ-003 CLK  input  1  clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low; clock CLK.
REQ-005 I_STB  input  1  one received ASCII byte valid this cycle; may be asserted every cycle.
REQ-006 I_DAT  input  8  received ASCII byte.
REQ-007 O_STB  output  1  single-cycle pulse: a complete valid message was parsed.
REQ-008 O_DAT  output  WIDTH*COUNT  parsed message; first-received word in the most significant WIDTH bits.
REQ-009 O_ERR  output  1  single-cycle pulse: malformed message detected.

Function
REQ-010 Message grammar SHALL be COUNT words of exactly WIDTH/4 hex digits each, MSB digit first, separated by '_' (8'h5F), terminated by LF (8'h0A) or CR (8'h0D).
REQ-011 Valid digits SHALL be '0'-'9' and 'A'-'F'; lowercase SHALL depend on REQ-024.
REQ-012 Bytes SHALL be consumed only when I_STB=1; I_DAT is ignored otherwise.
REQ-013 States SHALL be S_PARSE (collecting digits/separators) and S_SKIP (discarding until terminator).
REQ-014 S_PARSE digit: shift nibble into the working register, increment the digit counter; the (WIDTH/4+1)th digit of a word SHALL be an error.
REQ-015 S_PARSE '_': valid only when the digit counter = WIDTH/4 and the word counter < COUNT-1; it SHALL clear the digit counter and increment the word counter; otherwise error.
REQ-016 S_PARSE terminator with word counter = COUNT-1 and digit counter = WIDTH/4: O_DAT SHALL be loaded and O_STB SHALL pulse in the cycle after the terminator byte; counters SHALL clear.
REQ-017 S_PARSE terminator with zero digits and zero words (empty line, e.g. LF after CR) SHALL be ignored silently.
REQ-018 S_PARSE terminator in any other position SHALL be an error; counters SHALL clear and the state SHALL remain S_PARSE.
REQ-019 Any other byte in S_PARSE SHALL be an error and SHALL move the FSM to S_SKIP.
REQ-020 Error: O_ERR SHALL pulse in the cycle after the offending byte, exactly once per malformed message; O_DAT SHALL be unchanged and O_STB SHALL not pulse for that message.
REQ-021 S_SKIP SHALL discard all bytes; a terminator SHALL clear the counters and return to S_PARSE without O_STB or O_ERR.
REQ-022 O_DAT SHALL hold its value between valid messages; O_STB and O_ERR SHALL never be asserted in the same cycle.

Reset
REQ-023 On RST=0 at a clock edge: state S_PARSE, counters 0, working register 0, O_DAT 0, O_STB 0, O_ERR 0; any partial message is discarded. Parsing resumes on the first byte after RST returns high.

Configuration
REQ-024 MESSAGE_PARSER_LOWERCASE_EN defined: 'a'-'f' SHALL be accepted as hex digits 10-15; undefined: 'a'-'f' SHALL be errors per REQ-019.

Structure
REQ-025 A shared package/header SHALL hold the character constants (CHAR_SEP, CHAR_LF, CHAR_CR) and the FSM state encodings, shared with message_formatter.
REQ-026 A sub-module hex_char_decoder SHALL map a byte to {valid, nibble}, with the lowercase option of REQ-024 applied inside it.
REQ-027 The digit counter SHALL be clog2(WIDTH/4+1) bits wide and the word counter clog2(COUNT) bits wide (minimum 1 bit each).

Verification (WIDTH=32, COUNT=2)
REQ-028 Bytes "01234567_ABCD4321\n", one per cycle -> O_STB one cycle after LF, O_DAT=64'h01234567ABCD4321, no O_ERR.
REQ-029 "0123G567_ABCD4321\n" -> O_ERR one cycle after 'G', no O_STB at LF, O_DAT unchanged; a following valid message parses correctly.
REQ-030 "0123456_ABCD4321\n" (short word) -> O_ERR after '_'; "01234567_ABCD4321_00000000\n" -> O_ERR after the second '_'; "01234567\n" -> O_ERR after LF.
REQ-031 "deadbeef_00000001\r\n" -> with macro: O_STB, O_DAT=64'hDEADBEEF00000001, and the LF is ignored; without macro: O_ERR after 'd', no O_STB.
REQ-032 RST=0 after "0123" -> all outputs 0; then "FFFFFFFF_00000000\n" -> O_DAT=64'hFFFFFFFF00000000.
REQ-033 I_STB toggled 0/1 randomly during a valid message -> same result as REQ-028; idle cycles have no effect.

Source files
------------

// File: rtl/message_parser_pkg.sv
// Shared definitions for the message parser/formatter pair: ASCII framing
// characters, FSM state encodings and a terminator helper.
package message_parser_pkg;

    localparam logic [7:0] CHAR_SEP = 8'h5F;  // '_'
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_CR  = 8'h0D;

    typedef enum logic {
        S_PARSE = 1'b0,
        S_SKIP  = 1'b1
    } parser_state_t;

    function automatic logic is_terminator(input logic [7:0] chr);
        return (chr == CHAR_LF) || (chr == CHAR_CR);
    endfunction

endpackage

// File: rtl/hex_char_decoder.sv
// Maps one ASCII byte to {valid, nibble}. Lowercase 'a'-'f' are accepted only
// when MESSAGE_PARSER_LOWERCASE_EN is defined.
module hex_char_decoder (
    input  logic [7:0] chr,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latches).
        valid  = 1'b0;
        nibble = 4'h0;
        if (chr >= 8'h30 && chr <= 8'h39) begin
            valid  = 1'b1;
            nibble = chr[3:0];
        end else if (chr >= 8'h41 && chr <= 8'h46) begin
            valid  = 1'b1;
            nibble = chr[3:0] + 4'd9;
        end
`ifdef MESSAGE_PARSER_LOWERCASE_EN
        else if (chr >= 8'h61 && chr <= 8'h66) begin
            valid  = 1'b1;
            nibble = chr[3:0] + 4'd9;
        end
`endif
    end

endmodule

// File: rtl/message_parser.sv
// Parses "HHHH..._HHHH...<LF|CR>" ASCII messages into COUNT packed words.
// Optional lowercase hex digits: define MESSAGE_PARSER_LOWERCASE_EN.
module message_parser
    import message_parser_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int COUNT = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     I_STB,
    input  logic [7:0]               I_DAT,
    output logic                     O_STB,
    output logic [WIDTH*COUNT-1:0]   O_DAT,
    output logic                     O_ERR
);

    localparam int DIGITS = WIDTH / 4;
    localparam int MSG_W  = WIDTH * COUNT;
    localparam int DCW    = ($clog2(DIGITS + 1) < 1) ? 1 : $clog2(DIGITS + 1);
    localparam int WCW    = ($clog2(COUNT) < 1) ? 1 : $clog2(COUNT);
    localparam logic [DCW-1:0] DIGIT_FULL = DCW'(DIGITS);
    localparam logic [WCW-1:0] WORD_LAST  = WCW'(COUNT - 1);

    parser_state_t    state, state_next;
    logic [DCW-1:0]   digit_cnt, digit_next;
    logic [WCW-1:0]   word_cnt, word_next;
    logic [MSG_W-1:0] work, work_next;
    logic             stb_next, err_next;

    logic             dec_valid;
    logic [3:0]       dec_nibble;
    logic             term;

    hex_char_decoder u_dec (
        .chr    (I_DAT),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    assign term = is_terminator(I_DAT);

    always_ff @(posedge CLK) begin
        // NOTE: the working register is real state, so it is reset like the rest.
        if (!RST) begin
            state     <= S_PARSE;
            digit_cnt <= '0;
            word_cnt  <= '0;
            work      <= '0;
            O_DAT     <= '0;
            O_STB     <= 1'b0;
            O_ERR     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state     <= state_next;
            digit_cnt <= digit_next;
            word_cnt  <= word_next;
            work      <= work_next;
            O_STB     <= stb_next;
            O_ERR     <= err_next;
            if (stb_next)
                O_DAT <= work;
        end
    end

    // The whole message shifts through one register, so the first word ends up on top.
    always_comb begin
        state_next = state;
        digit_next = digit_cnt;
        word_next  = word_cnt;
        work_next  = work;
        stb_next   = 1'b0;
        err_next   = 1'b0;
        if (I_STB) begin
            case (state)
                S_PARSE: begin
                    if (dec_valid) begin
                        if (digit_cnt == DIGIT_FULL) begin
                            err_next   = 1'b1;
                            state_next = S_SKIP;
                        end else begin
                            work_next  = {work[MSG_W-5:0], dec_nibble};
                            digit_next = digit_cnt + DCW'(1);
                        end
                    end else if (I_DAT == CHAR_SEP) begin
                        if (digit_cnt == DIGIT_FULL && word_cnt < WORD_LAST) begin
                            digit_next = '0;
                            word_next  = word_cnt + WCW'(1);
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_SKIP;
                        end
                    end else if (term) begin
                        digit_next = '0;
                        word_next  = '0;
                        if (word_cnt == WORD_LAST && digit_cnt == DIGIT_FULL)
                            stb_next = 1'b1;
                        else if (digit_cnt != '0 || word_cnt != '0)
                            err_next = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_SKIP;
                    end
                end
                S_SKIP: begin
                    // Remaining bytes of a bad message are dropped without further errors.
                    if (term) begin
                        state_next = S_PARSE;
                        digit_next = '0;
                        word_next  = '0;
                    end
                end
                default: state_next = S_PARSE;
            endcase
        end
    end

endmodule
